// File: rtl/brg_rf_wbq_pkg.sv
// Shared types for the register-file writeback queue: queue entry layout and
// the read-data source select. Entry widths are fixed here and must match the
// width_p / addr_width_lp parameters of brg_rf_wb_queue.
package brg_rf_wbq_pkg;

  localparam int wbq_width_lp      = 32;
  localparam int wbq_addr_width_lp = 5;

  typedef logic [wbq_width_lp-1:0]      wbq_data_t;
  typedef logic [wbq_addr_width_lp-1:0] wbq_addr_t;

  // One pending register writeback.
  typedef struct packed {
    wbq_addr_t addr;
    wbq_data_t data;
  } wbq_entry_t;

  // Where the registered read result comes from one cycle after a read.
  typedef enum logic [1:0] {
    RF    = 2'd0,
    QUEUE = 2'd1,
    ZERO  = 2'd2
  } rd_src_e;

endpackage

// File: rtl/brg_rf_wb_queue_if.sv
// Connection between the writeback-queue top (master: arbitration, port
// drive) and its CAM FIFO (slave: storage, drain head, address search).
interface brg_rf_wb_queue_if
  import brg_rf_wbq_pkg::*;
#(
  parameter int depth_p = 4
);

  localparam int cnt_w_lp = $clog2(depth_p + 1);

  // Up to two pushes per cycle; push0 is always the older of the pair.
  logic       push0_v;
  wbq_entry_t push0_entry;
  logic       push1_v;
  wbq_entry_t push1_entry;

  // Parallel lookup over the entries present this cycle.
  wbq_addr_t  search_addr;
  logic       hit;
  wbq_data_t  hit_data;

  // Drain side and occupancy.
  wbq_entry_t          head;
  logic                empty;
  logic [cnt_w_lp-1:0] count;

  modport master (
    output push0_v, push0_entry, push1_v, push1_entry, search_addr,
    input  hit, hit_data, head, empty, count
  );

  modport slave (
    input  push0_v, push0_entry, push1_v, push1_entry, search_addr,
    output hit, hit_data, head, empty, count
  );

endinterface

// File: rtl/brg_rf_wbq_cam_fifo.sv
// depth_p-entry writeback FIFO with a parallel address-match search.
// Accepts up to two pushes per cycle and always pops the head when non-empty;
// the owner guarantees via its ready logic that pushes never overflow.
module brg_rf_wbq_cam_fifo
  import brg_rf_wbq_pkg::*;
#(
  parameter int depth_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  brg_rf_wb_queue_if.slave   fifo_if
);

  localparam int ptr_w_lp = $clog2(depth_p);
  localparam int cnt_w_lp = $clog2(depth_p + 1);

  wbq_entry_t          mem_q [depth_p];
  wbq_entry_t          mem_d [depth_p];
  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                pop;
  logic [ptr_w_lp-1:0] idx;

  // Next-state: write pushed entries in age order, pop head whenever occupied.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    mem_d    = mem_q;
    pop      = (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    if (fifo_if.push0_v) begin
      mem_d[wr_ptr_q] = fifo_if.push0_entry;
    end
    if (fifo_if.push1_v) begin
      if (fifo_if.push0_v) begin
        mem_d[ptr_w_lp'(wr_ptr_q + 1'b1)] = fifo_if.push1_entry;
      end else begin
        mem_d[wr_ptr_q] = fifo_if.push1_entry;
      end
    end
    wr_ptr_d = wr_ptr_q + ptr_w_lp'(fifo_if.push0_v) + ptr_w_lp'(fifo_if.push1_v);
    if (pop) begin
      rd_ptr_d = ptr_w_lp'(rd_ptr_q + 1'b1);
    end
    count_d = count_q + cnt_w_lp'(fifo_if.push0_v) + cnt_w_lp'(fifo_if.push1_v)
            - cnt_w_lp'(pop);
  end

  // Search oldest to youngest over present entries so the youngest match wins.
  always_comb begin
    fifo_if.hit      = 1'b0;
    fifo_if.hit_data = '0;
    idx              = '0;
    for (int i = 0; i < depth_p; i++) begin
      idx = ptr_w_lp'(rd_ptr_q + ptr_w_lp'(i));
      if ((cnt_w_lp'(i) < count_q) && (mem_q[idx].addr == fifo_if.search_addr)) begin
        fifo_if.hit      = 1'b1;
        fifo_if.hit_data = mem_q[idx].data;
      end
    end
  end

  // Drain head and occupancy seen by the owner.
  always_comb begin
    fifo_if.head  = mem_q[rd_ptr_q];
    fifo_if.empty = (count_q == '0);
    fifo_if.count = count_q;
  end

  // Pointer and occupancy registers; reset flushes the queue.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  // NOTE: storage is not reset; a zero count already marks every slot invalid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/brg_rf_wb_queue.sv
// Register-file writeback queue. Buffers ALU and load/remote writebacks,
// drains one per cycle into the macro write port, and serves reads from the
// queue when it holds a newer value than the macro (so the macro never sees a
// read and a write of the same address in one cycle).
// Optional feature: define BRG_RF_WBQ_STATS_EN to count reads served from the
// queue on bypass_cnt_o; otherwise bypass_cnt_o is tied to zero.
module brg_rf_wb_queue
  import brg_rf_wbq_pkg::*;
#(
  parameter int width_p       = wbq_width_lp,
  parameter int addr_width_lp = wbq_addr_width_lp,
  parameter int depth_p       = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic                     alu_v_i,
  input  logic [addr_width_lp-1:0] alu_addr_i,
  input  logic [width_p-1:0]       alu_data_i,
  output logic                     alu_ready_o,

  input  logic                     mem_v_i,
  input  logic [addr_width_lp-1:0] mem_addr_i,
  input  logic [width_p-1:0]       mem_data_i,
  output logic                     mem_ready_o,

  input  logic                     rd_v_i,
  input  logic [addr_width_lp-1:0] rd_addr_i,
  output logic [width_p-1:0]       rd_data_o,

  output logic                     rf_cena_n_o,
  output logic [addr_width_lp-1:0] rf_aa_o,
  input  logic [width_p-1:0]       rf_qa_i,

  output logic                     rf_cenb_n_o,
  output logic [addr_width_lp-1:0] rf_ab_o,
  output logic [width_p-1:0]       rf_db_o,

  output logic                     empty_o,
  output logic [31:0]              bypass_cnt_o
);

  localparam int cnt_w_lp = $clog2(depth_p + 1);

  brg_rf_wb_queue_if #(.depth_p(depth_p)) fifo_if ();

  brg_rf_wbq_cam_fifo #(.depth_p(depth_p)) u_cam_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .fifo_if   (fifo_if)
  );

  logic              rd_nz;
  logic              rd_hit;
  rd_src_e           rd_src_d, rd_src_q;
  logic              rd_pend_d, rd_pend_q;
  logic [width_p-1:0] byp_data_d, byp_data_q;
  logic [width_p-1:0] held_d, held_q;

  // Readiness from registered count only; address-0 requests are accepted but dropped.
  always_comb begin
    alu_ready_o         = (fifo_if.count != cnt_w_lp'(depth_p));
    mem_ready_o         = (fifo_if.count <= cnt_w_lp'(depth_p - 2));
    fifo_if.push0_v     = alu_v_i && alu_ready_o && (alu_addr_i != '0);
    fifo_if.push0_entry = '{addr: alu_addr_i, data: alu_data_i};
    fifo_if.push1_v     = mem_v_i && mem_ready_o && (mem_addr_i != '0);
    fifo_if.push1_entry = '{addr: mem_addr_i, data: mem_data_i};
  end

  // Drain the head into the macro write port every occupied cycle.
  always_comb begin
    rf_cenb_n_o = !(reset_n_i && !fifo_if.empty);
    rf_ab_o     = fifo_if.head.addr;
    rf_db_o     = fifo_if.head.data;
    empty_o     = fifo_if.empty;
  end

  // Read lookup: queue hit bypasses the macro, miss reads it, address 0 reads zero.
  always_comb begin
    fifo_if.search_addr = rd_addr_i;
    rd_nz       = (rd_addr_i != '0);
    rd_hit      = rd_v_i && rd_nz && fifo_if.hit;
    rd_pend_d   = rd_v_i;
    rd_src_d    = rd_src_q;
    byp_data_d  = byp_data_q;
    rf_cena_n_o = 1'b1;
    rf_aa_o     = rd_addr_i;
    if (rd_v_i) begin
      if (!rd_nz) begin
        rd_src_d = ZERO;
      end else if (fifo_if.hit) begin
        rd_src_d   = QUEUE;
        byp_data_d = fifo_if.hit_data;
      end else begin
        rd_src_d    = RF;
        rf_cena_n_o = !reset_n_i;
      end
    end
  end

  // Read return: select the source of last cycle's read, else hold the last value.
  always_comb begin
    rd_data_o = held_q;
    if (rd_pend_q) begin
      unique case (rd_src_q)
        RF:      rd_data_o = rf_qa_i;
        QUEUE:   rd_data_o = byp_data_q;
        default: rd_data_o = '0;
      endcase
    end
    held_d = rd_data_o;
  end

  // Read-side registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_src_q   <= RF;
      rd_pend_q  <= 1'b0;
      byp_data_q <= '0;
      held_q     <= '0;
    end else begin
      rd_src_q   <= rd_src_d;
      rd_pend_q  <= rd_pend_d;
      byp_data_q <= byp_data_d;
      held_q     <= held_d;
    end
  end

`ifdef BRG_RF_WBQ_STATS_EN
  logic [31:0] bypass_cnt_d, bypass_cnt_q;

  // Count reads served from the queue; wraps naturally at 2^32.
  always_comb begin
    bypass_cnt_d = bypass_cnt_q + 32'(rd_hit);
  end

  // Bypass counter register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      bypass_cnt_q <= '0;
    end else begin
      bypass_cnt_q <= bypass_cnt_d;
    end
  end

  assign bypass_cnt_o = bypass_cnt_q;
`else
  assign bypass_cnt_o = '0;
`endif

endmodule

// File: tb/tb_brg_rf_wb_queue.sv
// Directed self-checking bench for brg_rf_wb_queue with a behavioural
// register-file macro (synchronous read, synchronous write) and a write log.
module tb_brg_rf_wb_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_v, mem_v, rd_v;
  logic [4:0]  alu_addr, mem_addr, rd_addr;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready;
  logic [31:0] rd_data;
  logic        rf_cena_n, rf_cenb_n;
  logic [4:0]  rf_aa, rf_ab;
  logic [31:0] rf_qa, rf_db;
  logic        empty;
  logic [31:0] bypass_cnt;

  logic [31:0] rf_mem [32];
  logic [36:0] wr_log [$];
  logic [36:0] exp_log [6];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_hits = 0;

  always #5 clk = ~clk;

  brg_rf_wb_queue dut (
    .clk_i        (clk),
    .reset_n_i    (rst_n),
    .alu_v_i      (alu_v),
    .alu_addr_i   (alu_addr),
    .alu_data_i   (alu_data),
    .alu_ready_o  (alu_ready),
    .mem_v_i      (mem_v),
    .mem_addr_i   (mem_addr),
    .mem_data_i   (mem_data),
    .mem_ready_o  (mem_ready),
    .rd_v_i       (rd_v),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .rf_cena_n_o  (rf_cena_n),
    .rf_aa_o      (rf_aa),
    .rf_qa_i      (rf_qa),
    .rf_cenb_n_o  (rf_cenb_n),
    .rf_ab_o      (rf_ab),
    .rf_db_o      (rf_db),
    .empty_o      (empty),
    .bypass_cnt_o (bypass_cnt)
  );

  // Register-file macro model plus log of every write it receives.
  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA000_0000 + 32'(i);
    rf_qa = '0;
    forever begin
      @(posedge clk);
      if (!rf_cenb_n) begin
        rf_mem[rf_ab] <= rf_db;
        wr_log.push_back({rf_ab, rf_db});
      end
      if (!rf_cena_n) rf_qa <= rf_mem[rf_aa];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    alu_v = 0; alu_addr = '0; alu_data = '0;
    mem_v = 0; mem_addr = '0; mem_data = '0;
    rd_v  = 0; rd_addr  = '0;
  endtask

  // Drive point: just after the active edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Sample point: opposite edge.
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic alu(input logic [4:0] a, input logic [31:0] d);
    alu_v = 1; alu_addr = a; alu_data = d;
  endtask

  task automatic mem(input logic [4:0] a, input logic [31:0] d);
    mem_v = 1; mem_addr = a; mem_data = d;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #2;
    check("rst_cena", rf_cena_n, 1);
    check("rst_cenb", rf_cenb_n, 1);
    check("rst_empty", empty, 1);
    check("rst_alu_ready", alu_ready, 1);
    check("rst_mem_ready", mem_ready, 1);
    check("rst_rd_data", rd_data, 0);
    check("rst_bypass", bypass_cnt, 0);
    next(); next();
    rst_n = 1'b1;

    // Single ALU writeback reaches the macro the next cycle.
    alu(5'd5, 32'hDEAD_BEEF);
    sample();
    check("t1_cenb_pre", rf_cenb_n, 1);
    check("t1_alu_ready", alu_ready, 1);
    next(); idle(); sample();
    check("t1_cenb", rf_cenb_n, 0);
    check("t1_ab", rf_ab, 5);
    check("t1_db", rf_db, 32'hDEAD_BEEF);
    next(); sample();
    check("t1_cenb_after", rf_cenb_n, 1);
    check("t1_empty_after", empty, 1);

    // Same-cycle ALU and mem to r3: ALU value written first.
    next(); alu(5'd3, 32'h1); mem(5'd3, 32'h2); sample();
    check("t2_mem_ready", mem_ready, 1);
    next(); idle(); sample();
    check("t2_cenb0", rf_cenb_n, 0);
    check("t2_ab0", rf_ab, 3);
    check("t2_db0", rf_db, 32'h1);
    next(); sample();
    check("t2_cenb1", rf_cenb_n, 0);
    check("t2_ab1", rf_ab, 3);
    check("t2_db1", rf_db, 32'h2);
    next(); sample();
    check("t2_empty", empty, 1);

    // r7=0x11 then r7=0x22; read r7 while 0x22 is the head being drained.
    next(); alu(5'd7, 32'h11);
    next(); alu(5'd7, 32'h22);
    next(); idle(); rd_v = 1; rd_addr = 5'd7; sample();
    check("t3_cena", rf_cena_n, 1);
    exp_hits++;
    next(); idle(); sample();
    check("t3_rd_data", rd_data, 32'h22);

    // Two r7 entries present together: youngest wins.
    next(); alu(5'd7, 32'h33); mem(5'd7, 32'h44);
    next(); idle(); rd_v = 1; rd_addr = 5'd7; sample();
    check("t3b_cena", rf_cena_n, 1);
    exp_hits++;
    next(); idle(); sample();
    check("t3b_rd_data", rd_data, 32'h44);
    next(); sample();
    check("t3b_hold", rd_data, 32'h44);

    // Same-cycle enqueue is not visible: read goes to the macro.
    next(); alu(5'd9, 32'h99); rd_v = 1; rd_addr = 5'd9; sample();
    check("t4_cena", rf_cena_n, 0);
    check("t4_aa", rf_aa, 9);
    next(); idle(); sample();
    check("t4_rd_data", rd_data, 32'hA000_0009);
    next(); sample();
    check("t4_hold", rd_data, 32'hA000_0009);
    next(); rd_v = 1; rd_addr = 5'd9; sample();
    check("t4_miss_cena", rf_cena_n, 0);
    next(); idle(); sample();
    check("t4_rf_new", rd_data, 32'h99);

    // Address 0: write dropped, read returns zero without a macro read.
    next(); alu(5'd0, 32'hFFFF_FFFF);
    next(); idle(); rd_v = 1; rd_addr = 5'd0; sample();
    check("t5_cenb", rf_cenb_n, 1);
    check("t5_empty", empty, 1);
    check("t5_cena", rf_cena_n, 1);
    next(); idle(); sample();
    check("t5_rd_data", rd_data, 0);
`ifdef BRG_RF_WBQ_STATS_EN
    check("bypass_cnt", bypass_cnt, 64'(exp_hits));
`else
    check("bypass_cnt", bypass_cnt, 0);
`endif

    // Back-to-back dual pushes against a one-per-cycle drain.
    wr_log.delete();
    next(); alu(5'd10, 32'h100); mem(5'd20, 32'h200); sample();
    check("t6_c0_alu_rdy", alu_ready, 1);
    check("t6_c0_mem_rdy", mem_ready, 1);
    next(); alu(5'd11, 32'h101); mem(5'd21, 32'h201); sample();
    check("t6_c1_alu_rdy", alu_ready, 1);
    check("t6_c1_mem_rdy", mem_ready, 1);
    next(); alu(5'd12, 32'h102); mem(5'd22, 32'h202); sample();
    check("t6_c2_alu_rdy", alu_ready, 1);
    check("t6_c2_mem_rdy", mem_ready, 0);
    next(); alu(5'd13, 32'h103); mem(5'd23, 32'h203); sample();
    check("t6_c3_alu_rdy", alu_ready, 1);
    check("t6_c3_mem_rdy", mem_ready, 0);
    next(); idle();
    for (int i = 0; i < 6; i++) next();
    exp_log[0] = {5'd10, 32'h100};
    exp_log[1] = {5'd20, 32'h200};
    exp_log[2] = {5'd11, 32'h101};
    exp_log[3] = {5'd21, 32'h201};
    exp_log[4] = {5'd12, 32'h102};
    exp_log[5] = {5'd13, 32'h103};
    check("t6_log_size", 64'(wr_log.size()), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t6_log%0d", i), (i < wr_log.size()) ? wr_log[i] : 'x, exp_log[i]);
    end

    // Reset with three entries queued.
    next(); alu(5'd14, 32'h104); mem(5'd24, 32'h204);
    next(); alu(5'd15, 32'h105); mem(5'd25, 32'h205);
    next(); idle(); rd_v = 1; rd_addr = 5'd3; sample();
    check("t7_pre_empty", empty, 0);
    check("t7_pre_cenb", rf_cenb_n, 0);
    rst_n = 1'b0;
    wr_log.delete();
    #1;
    check("t7_cenb", rf_cenb_n, 1);
    check("t7_cena", rf_cena_n, 1);
    check("t7_empty", empty, 1);
    check("t7_alu_ready", alu_ready, 1);
    check("t7_mem_ready", mem_ready, 1);
    check("t7_rd_data", rd_data, 0);
    check("t7_bypass", bypass_cnt, 0);
    idle();
    next(); next();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) next();
    check("t7_no_writes", 64'(wr_log.size()), 0);
    check("t7_r25_untouched", rf_mem[25], 32'hA000_0019);
    check("t7_r15_untouched", rf_mem[15], 32'hA000_000F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
